mem_arbiter: RTL
================

# mem_arbiter

Merges the CPU's separate instruction and data memory ports onto one shared memory port. It sits directly downstream of `cpu`, between its `imem_*`/`dmem_*` ports and a single multi-cycle memory. The block latches single-cycle requests from either port and issues one memory transaction at a time. It routes each response back to the port that originated it, so the CPU's back-pressure stall logic sees ordinary `imem_resp`/`dmem_resp` behaviour.

## Interface
Parameters:
- D_PRIORITY, 1, when both ports have a pending request in IDLE: 1 = data first, 0 = instruction first

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  in  32  instruction request address
- imem_rmask  in  4  instruction read mask; nonzero = request this cycle
- imem_rdata  out  32  instruction read data, valid with imem_resp
- imem_resp  out  1  instruction response, one-cycle pulse
- dmem_addr  in  32  data request address
- dmem_rmask  in  4  data read mask
- dmem_wmask  in  4  data write mask; request when rmask|wmask nonzero
- dmem_wdata  in  32  data write data
- dmem_rdata  out  32  data read data, valid with dmem_resp
- dmem_resp  out  1  data response, one-cycle pulse
- mem_addr  out  32  shared memory address
- mem_rmask  out  4  shared read mask, nonzero for exactly one cycle per issue
- mem_wmask  out  4  shared write mask, nonzero for exactly one cycle per issue
- mem_wdata  out  32  shared write data
- mem_rdata  in  32  shared read data
- mem_resp  in  1  shared response, one-cycle pulse, ≥1 cycle after issue
- err  out  1  sticky protocol-violation flag

## Operation
- **Capture registers.**
  - One pending slot per port: I-slot holds addr and rmask; D-slot holds addr, rmask, wmask and wdata.
  - A request is captured at the clock edge of the cycle in which its mask is nonzero.
  - The CPU may drop the mask the next cycle.
- **FSM states.**
  - IDLE: no transaction outstanding.
  - BUSY_I: instruction transaction outstanding.
  - BUSY_D: data transaction outstanding.
- **IDLE behaviour.**
  - Neither slot valid: remain in IDLE.
  - Exactly one slot valid: drive that slot's fields onto mem_* for one cycle, then go to the matching BUSY state.
  - Both slots valid: D_PRIORITY selects which slot issues.
  - The issued slot is cleared on the issue edge.
- **BUSY_x behaviour.**
  - mem_* masks are held at 0.
  - On mem_resp: pulse x_resp in the same cycle, x_rdata = mem_rdata, go to IDLE.
- **Outputs outside a response.** imem_rdata/dmem_rdata = 0 when the respective resp is low.
- **Writes.** A D-write completes on mem_resp; dmem_resp pulses and dmem_rdata = mem_rdata, which the CPU ignores.
- **Address passthrough.** mem_addr is passed through as captured; the arbiter does not realign it.
- **Protocol violations.** All of the following set err, which stays set until reset:
  - A new request on a port whose slot is valid, or whose transaction is outstanding. The new request is dropped and the original is unaffected.
  - mem_resp while in IDLE. The pulse is otherwise ignored.
- **Reset (asynchronous).**
  - All slots invalid, state IDLE, err = 0.
  - All outputs 0: resp, rdata, mem masks, mem_addr and mem_wdata.
  - If reset lands mid-transaction, the transaction is abandoned. A mem_resp arriving after reset release hits IDLE and sets err.

## Timing
- Request at cycle t with the arbiter idle: mem issue at t+1; mem_resp at t+1+L gives x_resp in the same cycle t+1+L.
- Total CPU-visible latency is L+1 cycles.
- Back-to-back:
  - Response cycle r returns the FSM to IDLE at edge r.
  - The next pending slot issues at r+1.
  - Maximum throughput is one transaction per L+1 cycles.
- Simultaneous events:
  - Capture on one port in the same cycle the other port's response completes: both are processed. The new slot issues at r+1.
  - Capture and issue of the same port cannot coincide. Capture occurs at edge t and issue at t+1.
  - I and D requests in the same cycle: both captured. The priority slot issues at t+1; the other issues after the first response.
- No combinational path from any CPU request input to mem_*. Paths from mem_resp/mem_rdata to x_resp/x_rdata are combinational.

## Test plan
1. **Single read.** Reset, then imem_rmask=4'hF, addr=0x6000_0000 for one cycle; memory latency L=3.
   - mem_rmask=F, mem_addr=0x6000_0000 exactly one cycle later.
   - imem_resp exactly 4 cycles after the request, imem_rdata = mem_rdata; dmem_resp stays 0.
2. **Simultaneous I and D, D_PRIORITY=1.** I read 0x100 and D write 0x200 (wmask=4'h3, wdata=0xDEAD_BEEF) in the same cycle.
   - D issues first with mem_wmask=3, mem_wdata=0xDEAD_BEEF.
   - The I read issues the cycle after dmem_resp; imem_resp follows.
3. **Back-to-back fetches.** Five I requests, each issued the cycle after the previous imem_resp, with L=1.
   - Every fetch returns in 2 cycles, addresses are in order, and err stays 0.
4. **Duplicate request.** Second imem request while BUSY_I.
   - err rises the next cycle and stays set.
   - The original response is unaffected, and only one imem_resp is produced.
5. **Reset mid-transaction.** Assert rst while in BUSY_D.
   - All outputs go 0 immediately, without waiting for a clock edge.
   - A stale mem_resp after reset release produces no dmem_resp and sets err.
6. **D_PRIORITY=0 variant of scenario 2.** Same stimulus as scenario 2.
   - The I read issues first; the D write issues after imem_resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Merges the CPU's separate instruction and data memory ports onto a single
// shared, multi-cycle memory port. Each CPU port has a one-deep pending slot
// that captures a single-cycle request. The arbiter issues one memory
// transaction at a time and steers the response back to the originating port.
//
// Parameters:
//   D_PRIORITY  1 = data slot issues first when both are pending in IDLE,
//               0 = instruction slot issues first
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   imem_addr/rmask          instruction request (rmask != 0 means request)
//   imem_rdata/resp          instruction response (resp is a 1-cycle pulse)
//   dmem_addr/rmask/wmask/wdata  data request (rmask|wmask != 0 means request)
//   dmem_rdata/resp          data response (resp is a 1-cycle pulse)
//   mem_addr/rmask/wmask/wdata   shared memory issue (masks nonzero 1 cycle)
//   mem_rdata/resp           shared memory response
//   err                      sticky protocol-violation flag
module mem_arbiter #(
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t state;
    state_t state_next;

    logic        i_valid;
    logic [31:0] i_addr;
    logic [3:0]  i_rmask;

    logic        d_valid;
    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;

    logic i_req;
    logic d_req;
    logic i_busy;
    logic d_busy;
    logic i_capture;
    logic d_capture;
    logic issue_i;
    logic issue_d;
    logic violation;

    // A port is "busy" while its slot holds a request or its transaction is
    // outstanding; any new request on a busy port is dropped and flagged.
    assign i_req     = (|imem_rmask);
    assign d_req     = (|dmem_rmask) | (|dmem_wmask);
    assign i_busy    = i_valid || (state == BUSY_I);
    assign d_busy    = d_valid || (state == BUSY_D);
    assign i_capture = i_req && !i_busy;
    assign d_capture = d_req && !d_busy;

    assign violation = (i_req && i_busy) || (d_req && d_busy) ||
                       ((state == IDLE) && mem_resp);

    // Instruction slot. Capture needs an empty slot and issue needs a full
    // one, so the two can never collide on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_valid <= 1'b0;
            i_addr  <= '0;
            i_rmask <= '0;
        end else if (i_capture) begin
            i_valid <= 1'b1;
            i_addr  <= imem_addr;
            i_rmask <= imem_rmask;
        end else if (issue_i) begin
            i_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid <= 1'b0;
            d_addr  <= '0;
            d_rmask <= '0;
            d_wmask <= '0;
            d_wdata <= '0;
        end else if (d_capture) begin
            d_valid <= 1'b1;
            d_addr  <= dmem_addr;
            d_rmask <= dmem_rmask;
            d_wmask <= dmem_wmask;
            d_wdata <= dmem_wdata;
        end else if (issue_d) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (violation) begin
            err <= 1'b1;
        end
    end

    // A mem_resp seen in IDLE is a protocol error only; it does not block an
    // issue in the same cycle.
    always_comb begin
        state_next = state;
        issue_i    = 1'b0;
        issue_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid && (D_PRIORITY || !i_valid)) begin
                    issue_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (i_valid) begin
                    issue_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The memory side is driven only from slot registers, never directly from
    // CPU inputs, and is all-zero outside the single issue cycle.
    always_comb begin
        mem_addr  = '0;
        mem_rmask = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (issue_d) begin
            mem_addr  = d_addr;
            mem_rmask = d_rmask;
            mem_wmask = d_wmask;
            mem_wdata = d_wdata;
        end else if (issue_i) begin
            mem_addr  = i_addr;
            mem_rmask = i_rmask;
        end
    end

    // Responses are combinational from mem_resp so the CPU sees them in the
    // same cycle the memory answers.
    always_comb begin
        imem_resp  = (state == BUSY_I) && mem_resp;
        dmem_resp  = (state == BUSY_D) && mem_resp;
        imem_rdata = imem_resp ? mem_rdata : '0;
        dmem_rdata = dmem_resp ? mem_rdata : '0;
    end

endmodule
